// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_fifo
// Description : First-word-fall-through byte FIFO between the UART receiver and
//               transmitter, with sticky overflow flag. Optional refused-write
//               counter enabled by UART_ECHO_FIFO_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    // DEPTH is a power of two, so a full FIFO has only the count MSB set.
    localparam logic [ADDR_W:0] c_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_EMPTY = '0;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == c_EMPTY);
    assign w_push  = wr_valid && !w_full;
    assign w_pop   = rd_ready && !w_empty;
    assign w_drop  = wr_valid && w_full;

    assign wr_ready = !w_full;
    assign rd_valid = !w_empty;
    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A same-cycle drop wins over the clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_ECHO_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (clr_ovf) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            r_drop_cnt <= '0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_fifo
// Description : Self-checking bench for uart_echo_fifo: vector table, directed
//               corner sequences and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_fifo;

    localparam int c_DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    uart_echo_fifo #(
        .DATA_W (8),
        .DEPTH  (c_DEPTH),
        .ADDR_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    // Behavioural model: a byte queue plus the sticky flag and drop tally.
    logic [7:0] m_q[$];
    logic       m_ovf;
    int         m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step(input logic r, input logic wv, input logic [7:0] d,
                              input logic rr, input logic clr);
        bit full;
        bit drop;
        if (r) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            full = (m_q.size() == c_DEPTH);
            drop = wv && full;
            if (rr && m_q.size() > 0) void'(m_q.pop_front());
            if (wv && !full) m_q.push_back(d);
            if (drop) begin
                m_ovf   = 1'b1;
                m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    endtask

    task automatic compare_model();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
        chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < c_DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    // One clock: drive inputs, advance model, check state 1ns after the edge.
    task automatic cycle(input logic r, input logic wv, input logic [7:0] d,
                         input logic rr, input logic clr);
        rst      = r;
        wr_valid = wv;
        wr_data  = d;
        rd_ready = rr;
        clr_ovf  = clr;
        model_step(r, wv, d, rr, clr);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       r;
        logic       wv;
        logic [7:0] d;
        logic       rr;
        logic       clr;
        int         e_count;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] got;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        m_ovf    = 1'b0;
        m_drops  = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;

        //          r  wv d      rr clr  cnt val data   ovf
        vecs[0]  = '{1, 1, 8'h55, 0, 0,   0, 0, 8'h00, 0};
        vecs[1]  = '{1, 1, 8'h66, 0, 0,   0, 0, 8'h00, 0};
        vecs[2]  = '{0, 1, 8'hA5, 0, 0,   1, 1, 8'hA5, 0};
        vecs[3]  = '{0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0};
        vecs[4]  = '{0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0};
        vecs[5]  = '{0, 1, 8'h11, 1, 0,   1, 1, 8'h11, 0};
        vecs[6]  = '{0, 1, 8'h22, 1, 0,   1, 1, 8'h22, 0};
        vecs[7]  = '{0, 1, 8'h33, 0, 0,   2, 1, 8'h22, 0};
        vecs[8]  = '{0, 0, 8'h00, 1, 1,   1, 1, 8'h33, 0};
        vecs[9]  = '{0, 0, 8'h00, 0, 0,   1, 1, 8'h33, 0};
        vecs[10] = '{0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0};
        vecs[11] = '{0, 1, 8'h7E, 1, 0,   1, 1, 8'h7E, 0};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].r, vecs[i].wv, vecs[i].d, vecs[i].rr, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
        end

        // Fill, partial drain, refill across the pointer wrap, full drain.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, 0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h10 + i), 0, 0);
        chk("refill_count", 32'(count), 32'd16);

        // Overflow while full, then clear.
        cycle(0, 1, 8'hEE, 0, 0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        cycle(0, 0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        for (int i = 0; i < 16; i++) begin
            got = rd_data;
            chk($sformatf("drain%0d", i), 32'(got), 32'(8'h04 + i));
            cycle(0, 0, 8'h00, 1, 0);
        end
        chk("drain_valid", 32'(rd_valid), 32'd0);

        // Steady push+pop at count 5, then push+pop while full.
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h50 + i), 1, 0);
        chk("sim_count", 32'(count), 32'd5);
        chk("sim_head", 32'(rd_data), 32'h55);
        for (int i = 0; i < 11; i++) cycle(0, 1, 8'(8'h60 + i), 0, 0);
        cycle(0, 1, 8'hDD, 1, 0);
        chk("full_pp_count", 32'(count), 32'd15);
        chk("full_pp_ovf", 32'(overflow), 32'd1);
        // Drop and clear in the same cycle: the drop wins.
        cycle(0, 1, 8'h01, 0, 0);
        cycle(0, 1, 8'h02, 0, 1);
        chk("drop_vs_clr_ovf", 32'(overflow), 32'd1);

        // Reset mid-stream.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h70 + i), 0, 0);
        chk("mid_pre_count", 32'(count), 32'd7);
        cycle(1, 1, 8'h99, 0, 0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        cycle(0, 1, 8'h3C, 0, 0);
        chk("mid_readback", 32'(rd_data), 32'h3C);

        // Randomized traffic with phases biased toward full and empty.
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 85 : 30;
            pr = (ph % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 250; i++) begin
                cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 99) < pw),
                      8'($urandom),
                      ($urandom_range(0, 99) < pr),
                      ($urandom_range(0, 99) < 8));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
